ams_pwm_dac: RTL
================

// Module: ams_pwm_dac
// PURPOSE
//  Consumes one 24-bit PWM DAC word (as driven on dac_a_o..dac_d_o of the AMS register block) and
//  generates the dithered PWM bitstream feeding the external RC-filtered slow analog output.
//  One instance per channel (4 total), clocked on the fast PWM clock. Word = [23:16] base
//  duty in clocks, [15:0] per-sub-period dither mask. Config is applied glitch-free at frame edges.
// PARAMETERS
//  CYCLE_LEN  156  clocks per PWM sub-period (full-scale duty); must be 2..255
//  CNT_W      8    width of sub-period counter; must satisfy 2^CNT_W >= CYCLE_LEN
// PORTS
//  clk_i         in   1   PWM clock; all logic on rising edge
//  rstn_i        in   1   reset, asynchronous assert, active-low
//  cfg_i         in   24  DAC word, quasi-static, synchronous to clk_i
//  enable_i      in   1   1 = run; 0 = hold counters at 0, output low
//  pwm_o         out  1   PWM bitstream (registered)
//  frame_o       out  1   1-cycle pulse, first output clock of each 16-sub-period frame
//  cfg_active_o  out  24  shadow word currently driving the output
// BEHAVIOUR
//  - Reset (rstn_i=0, async): cfg_r, shadow, cnt, slot <= 0; pwm_o=0, frame_o=0, cfg_active_o=0.
//  - Input stage: cfg_r <= cfg_i every clock (1 clock latency before use).
//  - Counters: cnt 0..CYCLE_LEN-1, wraps to 0; slot (4 bit) 0..15, increments when cnt wraps,
//    wraps 15->0. Frame = 16 sub-periods = 16*CYCLE_LEN clocks (2496 at default).
//  - enable_i=0: next clock cnt=0, slot=0; shadow <= cfg_r every clock; pwm_o<=0, frame_o<=0.
//  - enable_i=1: shadow <= cfg_r only at end-of-frame (cnt==CYCLE_LEN-1 && slot==15);
//    otherwise held. Mid-frame cfg_i changes never affect the current frame.
//  - Duty for slot k: duty = base + mask[k], 9-bit unsigned (no overflow); base=shadow[23:16],
//    mask=shadow[15:0].
//  - Output: pwm_o <= enable_i && (cnt < duty), evaluated on current (cnt,slot); one clock
//    latency from counter state to pin. duty >= CYCLE_LEN -> high whole sub-period (saturation,
//    no wrap); duty=0 -> low whole sub-period. High clocks per frame = sum_k min(base+mask[k],CYCLE_LEN).
//  - frame_o <= enable_i && cnt==0 && slot==0; aligned with the first pwm_o clock of the frame.
//  - cfg_active_o = shadow (combinational from register, no extra latency).
//  - Enable rise: first frame starts at cnt=0,slot=0 with shadow = cfg_r from last disabled clock;
//    pwm_o and frame_o first valid one clock after the enable_i=1 edge is sampled.
//  - Enable fall mid-frame: frame aborted; next clock counters=0; pwm_o low from the following clock.
//  - rstn_i asserted mid-frame: all state and outputs clear immediately; after release, behaves
//    as enable rise from shadow=0 (output low for first frame unless disabled/reloaded).
// TESTING
//  1 cfg=0x4E0000, enable=1 -> pwm_o period 156 clocks, 78 high/78 low; frame_o every 2496 clocks.
//  2 cfg=0x4E0001 -> slot0 79 high, slots1-15 78 high; 1249 high clocks per frame.
//  3 cfg=0xFFFFFF -> pwm_o constant 1 (saturation); cfg=0x9BFFFF -> constant 1 (155+1=156).
//  4 cfg=0x000000 -> pwm_o constant 0, frame_o still pulses every 2496 clocks; cfg_active_o=0.
//  5 cfg 0x4E0000->0x9C0000 at slot 7 -> duty 78 until frame end; cfg_active_o and duty 156
//    take effect exactly at next frame_o pulse.
//  6 rstn_i low at slot 5 -> pwm_o, frame_o, cfg_active_o =0 same cycle; enable_i low mid-frame
//    -> pwm_o 0 within 2 clocks; re-enable -> frame_o one clock after sampled enable.

Source files
------------

// File: rtl/ams_pwm_dac.sv
// ams_pwm_dac: one channel of the dithered PWM DAC.
// Takes a 24-bit word: [23:16] is the base duty in clocks and [15:0] is a
// dither mask with one bit per sub-period. The word drives a registered PWM
// bitstream. A frame is 16 sub-periods. New words are only taken at frame
// edges, so the analog output never sees a partially applied setting.
module ams_pwm_dac #(
  parameter int CYCLE_LEN = 156,
  parameter int CNT_W     = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [23:0] cfg_i,
  input  logic        enable_i,
  output logic        pwm_o,
  output logic        frame_o,
  output logic [23:0] cfg_active_o
);

  // The duty is 9 bits wide (base + one dither bit). The comparison width
  // must hold both the counter and the duty.
  localparam int CMP_W = (CNT_W > 9) ? CNT_W : 9;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE_LEN - 1);

  logic [23:0]      r_cfg;
  logic [23:0]      r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_slot;
  logic             r_pwm;
  logic             r_frame;

  logic             w_cnt_wrap;
  logic             w_frame_end;
  logic [15:0]      w_mask;
  logic [8:0]       w_duty;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       w_slot_next;
  logic [23:0]      w_shadow_next;
  logic             w_pwm_next;
  logic             w_frame_next;

  // Duty of the current sub-period: base plus this slot's dither bit, no overflow.
  function automatic logic [8:0] slot_duty(input logic [23:0] word, input logic [3:0] slot);
    logic [15:0] mask;
    mask = word[15:0];
    return {1'b0, word[23:16]} + {8'd0, mask[slot]};
  endfunction

  // Decode the counter position and compute the duty for the current slot.
  always_comb begin
    w_cnt_wrap  = (r_cnt == CNT_LAST);
    w_frame_end = w_cnt_wrap && (r_slot == 4'd15);
    w_mask      = r_shadow[15:0];
    w_duty      = slot_duty(r_shadow, r_slot);
  end

  // Next-state for the counters, the shadow word and the output pins.
  // Because the counter never reaches CYCLE_LEN, any duty >= CYCLE_LEN
  // saturates to a fully high sub-period without wrapping.
  always_comb begin
    w_cnt_next    = r_cnt;
    w_slot_next   = r_slot;
    w_shadow_next = r_shadow;
    w_pwm_next    = 1'b0;
    w_frame_next  = 1'b0;
    if (!enable_i) begin
      // While disabled, track the input so the first frame starts from it.
      w_cnt_next    = {CNT_W{1'b0}};
      w_slot_next   = 4'd0;
      w_shadow_next = r_cfg;
    end else begin
      w_pwm_next   = (CMP_W'(r_cnt) < CMP_W'(w_duty));
      w_frame_next = (r_cnt == {CNT_W{1'b0}}) && (r_slot == 4'd0);
      if (w_cnt_wrap) begin
        w_cnt_next  = {CNT_W{1'b0}};
        w_slot_next = r_slot + 4'd1;
      end else begin
        w_cnt_next  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_slot_next = r_slot;
      end
      if (w_frame_end) begin
        w_shadow_next = r_cfg;
      end else begin
        w_shadow_next = r_shadow;
      end
    end
  end

  // Input stage: register the DAC word once before it is used.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cfg <= 24'd0;
    end else begin
      r_cfg <= cfg_i;
    end
  end

  // Counter, shadow and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt    <= {CNT_W{1'b0}};
      r_slot   <= 4'd0;
      r_shadow <= 24'd0;
      r_pwm    <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_slot   <= w_slot_next;
      r_shadow <= w_shadow_next;
      r_pwm    <= w_pwm_next;
      r_frame  <= w_frame_next;
    end
  end

  assign pwm_o        = r_pwm;
  assign frame_o      = r_frame;
  assign cfg_active_o = r_shadow;

endmodule
